// File: rtl/tank_pkg.sv
// Shared types and constants for the enemy tank AI and its movement/launcher peers.
package tank_pkg;

  localparam int unsigned POS_W  = 11;
  localparam int unsigned DIFF_W = 12;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    MOVE    = 2'd2,
    BLOCKED = 2'd3
  } ai_state_t;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam logic [KEY_W-1:0] KEY_DOWN  = 4'b0001;
  localparam logic [KEY_W-1:0] KEY_UP    = 4'b0010;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 4'b0100;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 4'b1000;

  // Direction excluded from the next turn; valid=0 means no exclusion.
  typedef struct packed {
    logic valid;
    dir_t dir;
  } excl_t;

  function automatic logic [KEY_W-1:0] dir2key(input dir_t d);
    logic [KEY_W-1:0] k;
    case (d)
      DIR_UP:    k = KEY_UP;
      DIR_RIGHT: k = KEY_RIGHT;
      DIR_DOWN:  k = KEY_DOWN;
      default:   k = KEY_LEFT;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/enemy_tank_ai_if.sv
// Frame/collision/position inputs and key/fire outputs between a tank instance and its AI.
interface enemy_tank_ai_if;
  import tank_pkg::*;

  logic             startOfFrame;
  logic             brickCollision;
  logic             tankCollision;
  logic             runEn;
  logic             resetPos;
  logic [POS_W-1:0] myX;
  logic [POS_W-1:0] myY;
  logic [POS_W-1:0] playerX;
  logic [POS_W-1:0] playerY;
  logic [KEY_W-1:0] keyPressed;
  logic             fireReq;
  dir_t             aiDir;

  modport master (
    output startOfFrame, brickCollision, tankCollision, runEn, resetPos,
    output myX, myY, playerX, playerY,
    input  keyPressed, fireReq, aiDir
  );

  modport slave (
    input  startOfFrame, brickCollision, tankCollision, runEn, resetPos,
    input  myX, myY, playerX, playerY,
    output keyPressed, fireReq, aiDir
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 15,13,12,10); a zero seed falls back to the default.
module lfsr16
  import tank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] seed_eff;
  logic              fb;

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign fb       = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= seed_eff;
    end else begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/enemy_tank_ai.sv
// Enemy tank driver: random/player-seeking direction choice, collision back-off, periodic fire.
module enemy_tank_ai
  import tank_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED            = 16'hACE1,
  parameter int unsigned       MIN_HOLD_FRAMES = 30,
  parameter logic [7:0]        HOLD_MASK       = 8'h3F,
  parameter int unsigned       BLOCK_FRAMES    = 8,
  parameter int unsigned       FIRE_PERIOD     = 45,
  parameter bit                CHASE_EN        = 1'b1,
  parameter int unsigned       INITIAL_DIR     = 1
) (
  input  logic           clk,
  input  logic           reset,
  enemy_tank_ai_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_BASE  = CNT_W'(MIN_HOLD_FRAMES);
  localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCK_FRAMES);
  localparam logic [CNT_W-1:0] FIRE_LAST  = CNT_W'(FIRE_PERIOD - 1);
  localparam dir_t             INIT_DIR   = 2'(INITIAL_DIR);

  ai_state_t         state, state_nx;
  dir_t              ai_dir, ai_dir_nx;
  dir_t              pick, turn_dir;
  logic [KEY_W-1:0]  key, key_nx;
  logic              fire, fire_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_nx;
  logic [CNT_W-1:0]  blk_cnt, blk_nx;
  logic [CNT_W-1:0]  fire_cnt, fire_cnt_nx;
  excl_t             excl, excl_nx;
  logic              coll, coll_prev, coll_prev_nx, coll_edge;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;
  logic [DIFF_W-1:0] dx, dy, adx, ady;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .seed  (SEED),
    .q     (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:8];

  assign coll      = bus.brickCollision | bus.tankCollision;
  assign coll_edge = coll & ~coll_prev;

  // Direction proposal for the TURN cycle: random, optionally steered along the dominant axis.
  always_comb begin
    dx   = {1'b0, bus.playerX} - {1'b0, bus.myX};
    dy   = {1'b0, bus.playerY} - {1'b0, bus.myY};
    adx  = dx[DIFF_W-1] ? (DIFF_W'(0) - dx) : dx;
    ady  = dy[DIFF_W-1] ? (DIFF_W'(0) - dy) : dy;
    pick = dir_t'(lfsr[1:0]);
    if (CHASE_EN && lfsr[3]) begin
      if ((adx >= ady) && (dx != '0)) begin
        pick = dx[DIFF_W-1] ? DIR_LEFT : DIR_RIGHT;
      end else if (dy != '0) begin
        pick = dy[DIFF_W-1] ? DIR_UP : DIR_DOWN;
      end
    end
    turn_dir = (excl.valid && (pick == excl.dir)) ? dir_t'(pick + 2'd1) : pick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.resetPos || !bus.runEn) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.startOfFrame) state_nx = TURN;
        TURN:    state_nx = MOVE;
        MOVE: begin
          if (coll_edge) begin
            state_nx = BLOCKED;
          end else if (bus.startOfFrame && (hold_cnt <= CNT_W'(1))) begin
            state_nx = TURN;
          end
        end
        BLOCKED: if (bus.startOfFrame && (blk_cnt <= CNT_W'(1))) state_nx = TURN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Counters, exclusion and the next values of the registered outputs.
  always_comb begin
    ai_dir_nx    = ai_dir;
    hold_nx      = hold_cnt;
    blk_nx       = blk_cnt;
    fire_cnt_nx  = fire_cnt;
    excl_nx      = excl;
    fire_nx      = 1'b0;
    coll_prev_nx = coll;
    if (bus.resetPos) begin
      ai_dir_nx    = INIT_DIR;
      hold_nx      = '0;
      blk_nx       = '0;
      fire_cnt_nx  = '0;
      excl_nx      = '0;
      coll_prev_nx = 1'b0;
    end else if (bus.runEn) begin
      if ((state != IDLE) && bus.startOfFrame) begin
        if (fire_cnt == FIRE_LAST) begin
          fire_nx     = 1'b1;
          fire_cnt_nx = '0;
        end else begin
          fire_cnt_nx = fire_cnt + CNT_W'(1);
        end
      end
      case (state)
        IDLE: if (bus.startOfFrame) excl_nx = '0;
        TURN: begin
          ai_dir_nx = turn_dir;
          hold_nx   = HOLD_BASE + CNT_W'(lfsr[7:0] & HOLD_MASK);
        end
        MOVE: begin
          if (coll_edge) begin
            blk_nx  = BLOCK_LOAD;
            excl_nx = '{valid: 1'b1, dir: ai_dir};
          end else if (bus.startOfFrame) begin
            hold_nx = hold_cnt - CNT_W'(1);
            if (hold_cnt <= CNT_W'(1)) excl_nx = '0;
          end
        end
        BLOCKED: if (bus.startOfFrame) blk_nx = blk_cnt - CNT_W'(1);
        default: ;
      endcase
    end
    key_nx = (state_nx == MOVE) ? dir2key(ai_dir_nx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ai_dir    <= INIT_DIR;
      key       <= '0;
      fire      <= 1'b0;
      hold_cnt  <= '0;
      blk_cnt   <= '0;
      fire_cnt  <= '0;
      excl      <= '0;
      coll_prev <= 1'b0;
    end else begin
      ai_dir    <= ai_dir_nx;
      key       <= key_nx;
      fire      <= fire_nx;
      hold_cnt  <= hold_nx;
      blk_cnt   <= blk_nx;
      fire_cnt  <= fire_cnt_nx;
      excl      <= excl_nx;
      coll_prev <= coll_prev_nx;
    end
  end

  assign bus.keyPressed = key;
  assign bus.fireReq    = fire;
  assign bus.aiDir      = ai_dir;

endmodule

// File: doc/enemy_tank_ai.md
Name: enemy_tank_ai

Overview:
- Autonomous driver for enemy tanks; produces the 4-bit key vector that a tank movement block consumes in place of a keyboard.
- Sits between the collision/position outputs of an enemy tank's movement instance and that same instance's key input. Also drives the enemy missile launcher's fire request.
- Decides direction from an internal LFSR, optionally biased toward the player, and reacts to brick/tank collisions by pausing and then turning.

Parameters:
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'hACE1.
- MIN_HOLD_FRAMES, 30, minimum number of frames to hold a chosen direction.
- HOLD_MASK, 8'h3F, mask on lfsr[7:0]; the result is added to MIN_HOLD_FRAMES.
- BLOCK_FRAMES, 8, number of frames to stand still after a collision.
- FIRE_PERIOD, 45, number of frames between fire requests (must be ≥ 2).
- CHASE_EN, 1, when 1, enables the player-seeking bias.
- INITIAL_DIR, 1, direction code after reset (0 up, 1 right, 2 down, 3 left).

Ports:
- clk  in  1  system clock; the block's single clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-clock pulse at the start of each frame.
- brickCollision  in  1  own tank touching a brick.
- tankCollision  in  1  own tank touching another tank.
- runEn  in  1  game running; when 0, the AI is idle.
- resetPos  in  1  level restart; same effect as reset except the LFSR is not re-seeded.
- myX, myY  in  11 each  own tank top-left position.
- playerX, playerY  in  11 each  player tank top-left position.
- keyPressed  out  4  one-hot key vector: bit0 down, bit1 up, bit2 left, bit3 right.
- fireReq  out  1  one-clock fire pulse.
- aiDir  out  2  current direction code.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, keyPressed=0, fireReq=0, aiDir=INITIAL_DIR.
  - holdCnt=0, blkCnt=0, fireCnt=0, lfsr=SEED, collPrev=0.
- LFSR:
  - 16-bit Fibonacci register that advances every clock, including in IDLE.
  - fb = l[15]^l[13]^l[12]^l[10]; next value = {l[14:0], fb}.
- coll = brickCollision | tankCollision. collEdge = coll & ~collPrev; collPrev is registered every clock.
- States and transitions:
  - IDLE:
    - keyPressed=0.
    - If runEn=1 and startOfFrame=1, go to TURN with excl=none.
  - TURN (exactly one clock):
    - Default direction: d = lfsr[1:0].
    - If CHASE_EN=1 and lfsr[3]=1, compute dx = playerX−myX and dy = playerY−myY as signed 12-bit values.
      - If |dx| ≥ |dy| and dx ≠ 0: d = right when dx>0, else left.
      - Else if dy ≠ 0: d = down when dy>0, else up.
      - Else (dx=dy=0): keep the random d.
    - If d == excl, replace it with d = (d+1) mod 4.
    - Load aiDir=d and holdCnt = MIN_HOLD_FRAMES + (lfsr[7:0] & HOLD_MASK).
    - Next state is MOVE.
  - MOVE:
    - keyPressed = onehot(aiDir), registered, valid from the clock after TURN.
    - If collEdge=1: go to BLOCKED, set blkCnt=BLOCK_FRAMES, excl=aiDir.
    - Else, on startOfFrame: decrement holdCnt. When it reaches 0, go to TURN with excl=none.
    - If collEdge and hold expiry occur in the same clock, collEdge wins.
  - BLOCKED:
    - keyPressed=0.
    - On startOfFrame, decrement blkCnt. When it reaches 0, go to TURN with the stored excl.
    - Further collisions while BLOCKED are ignored.
- Fire:
  - fireCnt increments on startOfFrame while runEn=1 and state≠IDLE.
  - When fireCnt == FIRE_PERIOD−1 on a startOfFrame, set fireReq=1 for exactly one clock and clear fireCnt to 0.
  - fireReq is never asserted in IDLE.
- runEn deassertion: in the next clock, state=IDLE, keyPressed=0, fireReq=0. Counters hold; aiDir holds.
- resetPos=1 (with runEn=0): same effect as reset, except the LFSR keeps running.
- Direction-to-key mapping: up=4'b0010, right=4'b1000, down=4'b0001, left=4'b0100. The mapping matches the tank direction code used by tank movement.
- keyPressed always has at most one bit set.

Decomposition:
- Shared package (tank_pkg):
  - typedef ai_state_t {IDLE, TURN, MOVE, BLOCKED}.
  - typedef dir_t (2-bit) with constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - Key one-hot constants KEY_DOWN, KEY_UP, KEY_LEFT, KEY_RIGHT.
  - Function dir2key.
- One natural sub-module: lfsr16 (clk, reset, load, seed, q), which is reusable by other random spawners.

Test Plan:
1. Reset with SEED=16'hACE1 → keyPressed=0, fireReq=0, aiDir=1. After one clock, lfsr=16'h59C3.
2. runEn=1, CHASE_EN=0, one startOfFrame → TURN, then MOVE. keyPressed is one-hot matching onehot(lfsr[1:0] at TURN). The direction holds for exactly MIN_HOLD_FRAMES+(lfsr[7:0]&HOLD_MASK) frames before the next TURN.
3. In MOVE with dir=right, pulse brickCollision high for 3 clocks → keyPressed=0 from the next clock. After 8 startOfFrame pulses the block enters TURN; the new aiDir ≠ 1 in all 500 randomized trials.
4. CHASE_EN=1, force lfsr[3]=1 via SEED choice, myX=100, playerX=300, myY=playerY=50 → aiDir=1 and keyPressed=4'b1000.
5. runEn=1 in MOVE for 90 frames with FIRE_PERIOD=45 → fireReq pulses exactly twice, each one clock wide, at frames 45 and 90. With runEn=0, no pulses occur.
6. Collision edge coinciding with the hold-expiry startOfFrame → BLOCKED, not TURN. Asserting reset mid-BLOCKED → IDLE and all outputs at reset values on the next clock.
